// File: rtl/idm_wait_responder.sv
// idm_wait_responder
//   Unified instruction/data memory responder for the multicycle CPU. Accepts
//   word read/write requests on a req/ready handshake. Inserts LATENCY wait
//   states, then gives a one-cycle ready strobe with registered rdata/err.
//   The storage array "memory" is word-indexed and is never cleared by reset,
//   so benches can preload it hierarchically.
//
// Ports
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset (aborts any pending transaction)
//   req    : request valid (level, held until ready)
//   we     : 1 = write, 0 = read; sampled at accept
//   addr   : byte address; sampled at accept; word index = addr[ADDR_BITS+1:2]
//   wdata  : write data; sampled at accept
//   rdata  : registered read data; updated only by read responses
//   ready  : one-cycle response strobe
//   busy   : high while a transaction is accepted but not yet responded
//   err    : out-of-range (or misaligned) flag for the current response
//
// Optional feature: define IDM_ALIGN_CHECK_EN to treat addr[1:0] != 0 as an
//   error, handled the same way as an out-of-range access.

module idm_wait_responder #(
  parameter int DEPTH     = 256,
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        err
);

`ifdef IDM_ALIGN_CHECK_EN
  localparam logic ALIGN_CHK = 1'b1;
`else
  localparam logic ALIGN_CHK = 1'b0;
`endif

  localparam logic [3:0] LAT_M1 = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);
  localparam logic       ZERO_LAT = (LATENCY == 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  logic [31:0] memory [DEPTH];

  state_t      state;
  logic [3:0]  cnt;
  logic        cap_we;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;

  logic                 accept;
  logic                 to_resp;
  logic                 to_wait;
  logic                 sel_we;
  logic [31:0]          sel_addr;
  logic [31:0]          sel_wdata;
  logic                 bad;
  logic [ADDR_BITS-1:0] idx;

  // With zero latency the response edge is the accept edge, so the memory
  // access must use the live request inputs instead of the captured copy.
  always_comb begin
    accept    = ((state == IDLE) || (state == RESP)) && req;
    to_resp   = (accept && ZERO_LAT) || ((state == WAIT) && (cnt == 4'd0));
    to_wait   = (accept && !ZERO_LAT) || ((state == WAIT) && (cnt != 4'd0));
    sel_we    = (state == WAIT) ? cap_we    : we;
    sel_addr  = (state == WAIT) ? cap_addr  : addr;
    sel_wdata = (state == WAIT) ? cap_wdata : wdata;
    bad       = (sel_addr[31:ADDR_BITS+2] != '0) ||
                (ALIGN_CHK && (sel_addr[1:0] != 2'b00));
    idx       = sel_addr[ADDR_BITS+1:2];
  end

  // Storage has no reset; rst only blocks a write at an edge where it is high.
  always_ff @(posedge clk) begin
    if (!rst && to_resp && sel_we && !bad)
      memory[idx] <= sel_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      rdata     <= '0;
      ready     <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      ready <= to_resp;
      busy  <= to_wait;
      if (to_resp) begin
        err <= bad;
        if (!sel_we)
          rdata <= bad ? 32'd0 : memory[idx];
      end
      unique case (state)
        IDLE, RESP: begin
          if (req) begin
            cap_we    <= we;
            cap_addr  <= addr;
            cap_wdata <= wdata;
            if (ZERO_LAT) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= LAT_M1;
            end
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          // request inputs are ignored here; captured values drive the access
          if (cnt == 4'd0) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_idm_wait_responder.sv
// Directed bench: u_a (LATENCY=2) covers latency, write/read, range, alignment
// and mid-transaction reset; u_b (LATENCY=0) covers back-to-back responses.
module tb_idm_wait_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_req = 0, a_we = 0;
  logic [31:0] a_addr = 0, a_wdata = 0, a_rdata;
  logic        a_ready, a_busy, a_err;
  logic        b_req = 0, b_we = 0;
  logic [31:0] b_addr = 0, b_wdata = 0, b_rdata;
  logic        b_ready, b_busy, b_err;

  idm_wait_responder #(.DEPTH(256), .ADDR_BITS(8), .LATENCY(2)) u_a (
    .clk(clk), .rst(rst), .req(a_req), .we(a_we), .addr(a_addr),
    .wdata(a_wdata), .rdata(a_rdata), .ready(a_ready), .busy(a_busy), .err(a_err));

  idm_wait_responder #(.DEPTH(256), .ADDR_BITS(8), .LATENCY(0)) u_b (
    .clk(clk), .rst(rst), .req(b_req), .we(b_we), .addr(b_addr),
    .wdata(b_wdata), .rdata(b_rdata), .ready(b_ready), .busy(b_busy), .err(b_err));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // results of the last do_a transaction
  int          lat, bcnt;
  logic [31:0] r_rdata;
  logic        r_err;

  // one transaction on u_a: req offered at negedge, accepted at next posedge,
  // then outputs sampled on each negedge until ready (bounded)
  task automatic do_a(input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    a_req = 1'b1; a_we = w; a_addr = a; a_wdata = d;
    @(posedge clk); #1;
    a_req = 1'b0;
    lat = 0; bcnt = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (a_busy) bcnt++;
      if (a_ready || lat > 20) break;
    end
    r_rdata = a_rdata;
    r_err   = a_err;
    if (!a_ready) chk("timeout", 32'd0, 32'd1);
  endtask

  logic saw_ready;

  initial begin
    u_a.memory[125] = 32'd512;
    u_a.memory[0]   = 32'h1234;
    u_a.memory[4]   = 32'd3;
    u_b.memory[0]   = 32'hA;
    u_b.memory[1]   = 32'hB;
    u_b.memory[2]   = 32'hC;
    repeat (3) @(posedge clk);
    #1 chk("rst_ready", {31'd0, a_ready}, 32'd0);
    chk("rst_busy",  {31'd0, a_busy},  32'd0);
    chk("rst_err",   {31'd0, a_err},   32'd0);
    chk("rst_rdata", a_rdata, 32'd0);
    rst = 1'b0;

    // preload and read
    do_a(1'b0, 32'd500, 32'd0);
    chk("rd_lat",   lat, 32'd3);
    chk("rd_busy",  bcnt, 32'd2);
    chk("rd_data",  r_rdata, 32'd512);
    chk("rd_err",   {31'd0, r_err}, 32'd0);
    @(negedge clk);
    chk("rd_pulse", {31'd0, a_ready}, 32'd0);

    // write then read
    do_a(1'b1, 32'd512, 32'd55);
    chk("wr_lat",   lat, 32'd3);
    chk("wr_err",   {31'd0, r_err}, 32'd0);
    chk("wr_rdata_hold", r_rdata, 32'd512);
    chk("wr_mem",   u_a.memory[128], 32'd55);
    do_a(1'b0, 32'd512, 32'd0);
    chk("raw_data", r_rdata, 32'd55);

    // out of range: idx bits of 1024 alias word 0, which must stay intact
    do_a(1'b1, 32'd1024, 32'hFFFF);
    chk("oor_wr_err", {31'd0, r_err}, 32'd1);
    chk("oor_mem0",   u_a.memory[0], 32'h1234);
    do_a(1'b0, 32'd1024, 32'd0);
    chk("oor_rd_err",  {31'd0, r_err}, 32'd1);
    chk("oor_rd_data", r_rdata, 32'd0);
    do_a(1'b0, 32'd0, 32'd0);
    chk("ok_rd_err",  {31'd0, r_err}, 32'd0);
    chk("ok_rd_data", r_rdata, 32'h1234);

    // alignment
    do_a(1'b0, 32'd502, 32'd0);
`ifdef IDM_ALIGN_CHECK_EN
    chk("align_err",  {31'd0, r_err}, 32'd1);
    chk("align_data", r_rdata, 32'd0);
`else
    chk("align_err",  {31'd0, r_err}, 32'd0);
    chk("align_data", r_rdata, 32'd512);
`endif

    // reset during WAIT aborts the write
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b1; a_addr = 32'd16; a_wdata = 32'd7;
    @(posedge clk); #1;
    a_req = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'd0, a_busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy0",  {31'd0, a_busy},  32'd0);
    chk("abort_ready0", {31'd0, a_ready}, 32'd0);
    chk("abort_err0",   {31'd0, a_err},   32'd0);
    chk("abort_rdata0", a_rdata, 32'd0);
    saw_ready = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (a_ready) saw_ready = 1'b1;
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (a_ready) saw_ready = 1'b1;
    end
    chk("abort_noready", {31'd0, saw_ready}, 32'd0);
    chk("abort_mem4",    u_a.memory[4],   32'd3);
    chk("abort_pre125",  u_a.memory[125], 32'd512);
    chk("abort_pre128",  u_a.memory[128], 32'd55);

    // back-to-back reads on the zero-latency instance
    @(negedge clk);
    b_req = 1'b1; b_we = 1'b0; b_addr = 32'd0;
    @(posedge clk); #1 b_addr = 32'd4;
    @(negedge clk);
    chk("b2b_rdy0", {31'd0, b_ready}, 32'd1);
    chk("b2b_d0",   b_rdata, 32'hA);
    @(posedge clk); #1 b_addr = 32'd8;
    @(negedge clk);
    chk("b2b_rdy1", {31'd0, b_ready}, 32'd1);
    chk("b2b_d1",   b_rdata, 32'hB);
    @(posedge clk); #1 b_req = 1'b0;
    @(negedge clk);
    chk("b2b_rdy2", {31'd0, b_ready}, 32'd1);
    chk("b2b_d2",   b_rdata, 32'hC);
    chk("b2b_busy", {31'd0, b_busy}, 32'd0);
    @(negedge clk);
    chk("b2b_idle", {31'd0, b_ready}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
